tinygrev_unit: RTL and testbench

Multi-cycle, area-minimal generalized-reverse (GREV) unit for the bit-manipulation datapath. On a start pulse it captures a 32-bit operand and a 5-bit control word. It then applies one butterfly stage per clock and reports the result with a single-cycle done pulse. It is intended as a slow coprocessor-style helper beside the main ALU.

---
 rtl/tinygrev_unit.sv | 75 +++++++
 tb/tb_tinygrev_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tinygrev_unit.sv
// Multi-cycle generalized-reverse (GREV) unit: one butterfly stage per clock,
// stages 0..4 applied in order, single-cycle done pulse when rd is final.
module tinygrev_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rd,
  output logic        busy,
  output logic        done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt;
  logic [4:0]  ctrl;
  logic        accept;
  logic        last;
  logic [31:0] stage;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)      state_d = S_RUN;
      S_RUN:   if (cnt == 3'd4) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    accept = start && !busy;
    last   = busy && (cnt == 3'd4);
  end

  // rd doubles as the working register; each stage is gated by its own ctrl bit.
  always_comb begin
    stage = rd;
    case (cnt)
      3'd0: if (ctrl[0]) stage = ((rd & 32'h5555_5555) << 1) | ((rd >> 1) & 32'h5555_5555);
      3'd1: if (ctrl[1]) stage = ((rd & 32'h3333_3333) << 2) | ((rd >> 2) & 32'h3333_3333);
      3'd2: if (ctrl[2]) stage = ((rd & 32'h0F0F_0F0F) << 4) | ((rd >> 4) & 32'h0F0F_0F0F);
      3'd3: if (ctrl[3]) stage = ((rd & 32'h00FF_00FF) << 8) | ((rd >> 8) & 32'h00FF_00FF);
      3'd4: if (ctrl[4]) stage = ((rd & 32'h0000_FFFF) << 16) | ((rd >> 16) & 32'h0000_FFFF);
      default: stage = rd;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd   <= '0;
      ctrl <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        rd   <= rs1;
        ctrl <= rs2;
        cnt  <= '0;
      end else if (busy) begin
        rd  <= stage;
        cnt <= last ? 3'd0 : cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_tinygrev_unit.sv
// Directed and random checks for tinygrev_unit: latency, results, ignored
// starts, reset abort, and in-order results against a software GREV model.
module tb_tinygrev_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] rs1;
  logic [4:0]  rs2;
  logic [31:0] rd;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  tinygrev_unit dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .rs1  (rs1),
    .rs2  (rs2),
    .rd   (rd),
    .busy (busy),
    .done (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  c;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] grev_model(input logic [31:0] a, input logic [4:0] c);
    logic [31:0] m [5];
    logic [31:0] x;
    m[0] = 32'h5555_5555; m[1] = 32'h3333_3333; m[2] = 32'h0F0F_0F0F;
    m[3] = 32'h00FF_00FF; m[4] = 32'h0000_FFFF;
    x = a;
    for (int unsigned k = 0; k < 5; k++)
      if (c[k]) x = ((x & m[k]) << (1 << k)) | ((x >> (1 << k)) & m[k]);
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called 1 time unit after an edge with the unit idle; returns after done is seen.
  task automatic run_op(input logic [31:0] a, input logic [4:0] c,
                        output logic [31:0] res, output int lat);
    start = 1'b1; rs1 = a; rs2 = c;
    tick();
    start = 1'b0; rs1 = $urandom; rs2 = 5'($urandom);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    chk("done_low_after_accept", {31'b0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    res = rd;
  endtask

  vec_t        vecs [12];
  logic [31:0] res;
  logic [31:0] held;
  int          lat;
  int          pulses;
  int          extra;

  initial begin
    vecs[0]  = '{32'h1234_5678, 5'd31, 32'h1E6A_2C48};
    vecs[1]  = '{32'h1234_5678, 5'd24, 32'h7856_3412};
    vecs[2]  = '{32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[3]  = '{32'h1234_5678, 5'd1,  32'h2138_A9B4};
    vecs[4]  = '{32'h1234_5678, 5'd16, 32'h5678_1234};
    vecs[5]  = '{32'h1234_5678, 5'd7,  32'h482C_6A1E};
    vecs[6]  = '{32'h1234_5678, 5'd2,  32'h48C1_59D2};
    vecs[7]  = '{32'h1234_5678, 5'd4,  32'h2143_6587};
    vecs[8]  = '{32'h1234_5678, 5'd8,  32'h3412_7856};
    vecs[9]  = '{32'h8000_0001, 5'd31, 32'h8000_0001};
    vecs[10] = '{32'hFFFF_0000, 5'd16, 32'h0000_FFFF};
    vecs[11] = '{32'h0000_0001, 5'd31, 32'h8000_0000};

    reset = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0;
    repeat (5) tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_rd", rd, 32'h0);
    reset = 1'b0;
    tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_rd", rd, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].c, res, lat);
      chk("vec_latency", lat, 32'd5);
      chk("vec_result", res, vecs[i].exp);
      chk("vec_busy_at_done", {31'b0, busy}, 32'd0);
      tick();
      chk("vec_done_one_cycle", {31'b0, done}, 32'd0);
      chk("vec_rd_held", rd, vecs[i].exp);
    end

    // Back-to-back: new start sampled on the edge right after the done cycle.
    run_op(32'hA5A5_0F0F, 5'd31, res, lat);
    chk("b2b_first", res, grev_model(32'hA5A5_0F0F, 5'd31));
    run_op(32'hDEAD_BEEF, 5'd24, res, lat);
    chk("b2b_latency", lat, 32'd5);
    chk("b2b_second", res, 32'hEFBE_ADDE);
    tick();

    // Start while busy is ignored.
    start = 1'b1; rs1 = 32'h1234_5678; rs2 = 5'd24;
    tick();
    start = 1'b0; rs1 = '0; rs2 = '0;
    tick();
    start = 1'b1; rs1 = 32'hFFFF_FFFF; rs2 = 5'd1;
    tick();
    start = 1'b0;
    pulses = 0;
    held = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        pulses++;
        held = rd;
      end
      tick();
    end
    chk("ignored_start_pulses", pulses, 32'd1);
    chk("ignored_start_result", held, 32'h7856_3412);
    chk("ignored_start_rd_held", rd, 32'h7856_3412);
    chk("ignored_start_idle", {31'b0, busy}, 32'd0);

    // Reset sampled at E3 aborts the operation.
    start = 1'b1; rs1 = 32'hCAFE_F00D; rs2 = 5'd31;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_rd", rd, 32'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      tick();
    end
    chk("abort_no_pulse", pulses, 32'd0);
    run_op(32'h1234_5678, 5'd31, res, lat);
    chk("after_abort_latency", lat, 32'd5);
    chk("after_abort_result", res, 32'h1E6A_2C48);
    tick();

    extra = 0;
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      logic [4:0]  c;
      int          gap;
      a = $urandom;
      c = 5'($urandom);
      run_op(a, c, res, lat);
      chk("rand_latency", lat, 32'd5);
      chk("rand_result", res, grev_model(a, c));
      gap = $urandom_range(12, 5);
      for (int g = 0; g < gap; g++) begin
        tick();
        if (done) extra++;
      end
    end
    chk("rand_no_extra_done", extra, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
